// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_pkg
//  Purpose  : Shared constants for the I2C configuration sequencer: state
//             encoding, table-entry field positions, end marker and byte
//             indices within one 3-byte register write.
//  Revision : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // Sequencer states
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_CHECK     = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_GAP       = 3'd5;

    // Table entry layout {dev, reg, val}
    localparam int DEV_MSB = 23;
    localparam int DEV_LSB = 16;
    localparam int REG_MSB = 15;
    localparam int REG_LSB = 8;
    localparam int VAL_MSB = 7;
    localparam int VAL_LSB = 0;

    // Device-address byte that terminates the table
    localparam logic [7:0] END_MARKER_DEFAULT = 8'hFF;

    // Position of the byte currently on tx_data within a transaction
    localparam logic [1:0] BYTE_DEV = 2'd0;
    localparam logic [1:0] BYTE_REG = 2'd1;
    localparam logic [1:0] BYTE_VAL = 2'd2;

endpackage
`default_nettype wire

// File: rtl/i2c_cfg_rom.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_cfg_rom
//  Purpose  : Synchronous table of I2C register writes for the front-end
//             bring-up. Data appears one clock after the address. Board
//             variants replace the entry_at() contents.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_cfg_rom
    import i2c_pkg::*;
#(
    parameter int TBL_AW = 5
)(
    input  logic              clk,
    input  logic [TBL_AW-1:0] addr,
    output logic [23:0]       data
);

    // Init list; every unlisted slot holds the end marker
    function automatic logic [23:0] entry_at(input logic [TBL_AW-1:0] a);
        logic [23:0] e;
        e = {END_MARKER_DEFAULT, 16'h0000};
        if (a == TBL_AW'(0)) begin
            e = 24'h90_01_55;
        end else if (a == TBL_AW'(1)) begin
            e = 24'h90_02_AA;
        end
        return e;
    endfunction

    // Registered read port
    always_ff @(posedge clk) begin
        data <= entry_at(addr);
    end

endmodule
`default_nettype wire

// File: rtl/i2c_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_config_sequencer
//  Purpose  : Walks a table of 3-byte I2C register writes and feeds them,
//             one byte per request, to the byte-level I2C transmitter, with
//             an inter-transaction gap and a per-transaction watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_config_sequencer
    import i2c_pkg::*;
#(
    parameter int         TBL_AW         = 5,
    parameter int         GAP_CYCLES     = 400,
    parameter int         TIMEOUT_CYCLES = 20000,
    parameter logic [7:0] END_MARKER     = END_MARKER_DEFAULT
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [23:0]       tbl_data,
    output logic [7:0]        tx_data,
    output logic              tx_data_ready,
    output logic              tx_en,
    input  logic              tx_data_req,
    input  logic              tx_done,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [TBL_AW:0]   entry_cnt
);

    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TBL_AW:0]   CNT_MAX   = {1'b1, {TBL_AW{1'b0}}};
    localparam logic [TBL_AW-1:0] ADDR_MAX  = {TBL_AW{1'b1}};

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [1:0]        byte_idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [WDOG_W-1:0] wdog_cnt;
    logic [7:0]        ent_reg;
    logic [7:0]        ent_val;

    logic in_xfer;
    logic wdog_expired;
    logic table_end;
    logic last_byte;
    logic gap_end;

    // entry_cnt MSB set means every slot has been written: stop even without a marker
    assign in_xfer      = (state == ST_SEND) || (state == ST_WAIT_DONE);
    assign wdog_expired = in_xfer && (wdog_cnt == WDOG_LAST);
    assign table_end    = (tbl_data[DEV_MSB:DEV_LSB] == END_MARKER) || entry_cnt[TBL_AW];
    assign last_byte    = (byte_idx == BYTE_VAL);
    assign gap_end      = (gap_cnt == GAP_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; watchdog expiry takes priority over transmitter events
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (start) state_nxt = ST_FETCH;
            ST_FETCH:     state_nxt = ST_CHECK;
            ST_CHECK:     state_nxt = table_end ? ST_IDLE : ST_SEND;
            ST_SEND: begin
                if (wdog_expired) begin
                    state_nxt = ST_IDLE;
                end else if (tx_data_req && last_byte) begin
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (wdog_expired) begin
                    state_nxt = ST_IDLE;
                end else if (tx_done) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP:       if (gap_end) state_nxt = ST_FETCH;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state so they follow reset immediately
    always_comb begin
        tx_en         = in_xfer;
        tx_data_ready = (state == ST_SEND);
        busy          = (state != ST_IDLE);
    end

    // Datapath: table pointer, byte shifter, counters and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_addr  <= '0;
            tx_data   <= '0;
            byte_idx  <= BYTE_DEV;
            gap_cnt   <= '0;
            wdog_cnt  <= '0;
            ent_reg   <= '0;
            ent_val   <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            entry_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tbl_addr  <= '0;
                        entry_cnt <= '0;
                        error     <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (table_end) begin
                        done <= 1'b1;
                    end else begin
                        tx_data  <= tbl_data[DEV_MSB:DEV_LSB];
                        ent_reg  <= tbl_data[REG_MSB:REG_LSB];
                        ent_val  <= tbl_data[VAL_MSB:VAL_LSB];
                        byte_idx <= BYTE_DEV;
                        wdog_cnt <= '0;
                    end
                end
                ST_SEND: begin
                    wdog_cnt <= wdog_cnt + WDOG_W'(1);
                    if (wdog_expired) begin
                        error <= 1'b1;
                    end else if (tx_data_req) begin
                        // Transmitter takes the current byte on this edge
                        case (byte_idx)
                            BYTE_DEV: begin
                                tx_data  <= ent_reg;
                                byte_idx <= BYTE_REG;
                            end
                            BYTE_REG: begin
                                tx_data  <= ent_val;
                                byte_idx <= BYTE_VAL;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_WAIT_DONE: begin
                    wdog_cnt <= wdog_cnt + WDOG_W'(1);
                    if (wdog_expired) begin
                        error <= 1'b1;
                    end else if (tx_done) begin
                        if (entry_cnt != CNT_MAX) begin
                            entry_cnt <= entry_cnt + (TBL_AW+1)'(1);
                        end
                        // Hold at the last slot rather than wrapping back to 0
                        if (tbl_addr != ADDR_MAX) begin
                            tbl_addr <= tbl_addr + TBL_AW'(1);
                        end
                        gap_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_config_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_config_sequencer
//  Purpose  : Self-checking bench for i2c_config_sequencer: random tables,
//             transmitter model, reference byte list and run-result queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_config_sequencer;

    localparam int AW     = 3;
    localparam int NENT   = 1 << AW;
    localparam int GAP    = 16;
    localparam int TMO    = 300;
    localparam int BUDGET = 6000;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] tbl_addr;
    logic [23:0]   tbl_data;
    logic [7:0]    tx_data;
    logic          tx_data_ready;
    logic          tx_en;
    logic          tx_data_req;
    logic          tx_done;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   entry_cnt;

    logic [23:0] rom_data;
    logic [23:0] model_data;
    logic        use_rom;
    logic        hang_done;
    logic        spurious_en;
    logic [23:0] tbl [NENT];

    int checks;
    int failures;

    // Scoreboard state
    logic [7:0] exp_bytes [$];
    int         exp_runs  [$];
    int bytes_seen, done_pulses, txdone_cnt, en_seen, en_run_len;
    int gap_cnt, addr_regress;
    bit gap_armed, prev_tx_en, prev_busy;
    logic [AW-1:0] prev_addr;

    i2c_config_sequencer #(
        .TBL_AW        (AW),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO),
        .END_MARKER    (8'hFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .tbl_addr     (tbl_addr),
        .tbl_data     (tbl_data),
        .tx_data      (tx_data),
        .tx_data_ready(tx_data_ready),
        .tx_en        (tx_en),
        .tx_data_req  (tx_data_req),
        .tx_done      (tx_done),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .entry_cnt    (entry_cnt)
    );

    i2c_cfg_rom #(.TBL_AW(AW)) rom (
        .clk (clk),
        .addr(tbl_addr),
        .data(rom_data)
    );

    assign tbl_data = use_rom ? rom_data : model_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Synchronous table model: address seen at an edge, data driven after it
    initial begin : rom_model
        logic [AW-1:0] a;
        model_data = '0;
        forever begin
            @(posedge clk);
            a = tbl_addr;
            #1 model_data = tbl[a];
        end
    end

    // Byte-level transmitter model with randomized request spacing
    initial begin : xmit_model
        bit xm_busy;
        int xm_timer;
        int xm_bytes;
        xm_busy = 0;
        xm_timer = 0;
        xm_bytes = 0;
        tx_data_req = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_data_req = 1'b0;
            tx_done = 1'b0;
            if (!tx_en) xm_busy = 0;
            if (!xm_busy) begin
                if (tx_en && tx_data_ready) begin
                    xm_busy = 1;
                    xm_bytes = 0;
                    xm_timer = int'($urandom_range(2, 12));
                end else if (spurious_en && busy && !tx_en && $urandom_range(0, 3) == 0) begin
                    tx_data_req = 1'b1;
                end
            end else if (xm_timer > 0) begin
                xm_timer--;
            end else if (xm_bytes < 3) begin
                tx_data_req = 1'b1;
                xm_bytes++;
                xm_timer = int'($urandom_range(2, 12));
            end else if (!hang_done) begin
                tx_done = 1'b1;
                xm_busy = 0;
            end
        end
    end

    // Monitor: compares consumed bytes and run results against the queues
    initial begin : monitor
        logic [7:0] eb;
        int er;
        bytes_seen = 0; done_pulses = 0; txdone_cnt = 0; en_seen = 0;
        en_run_len = 0; gap_cnt = 0; addr_regress = 0;
        gap_armed = 0; prev_tx_en = 0; prev_busy = 0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gap_armed = 0;
                prev_tx_en = 0;
                prev_busy = 0;
            end else begin
                if (tx_data_req && tx_en && tx_data_ready) begin
                    bytes_seen++;
                    if (exp_bytes.size() == 0) begin
                        check("byte_unexpected", 32'(tx_data), 32'hDEAD);
                    end else begin
                        eb = exp_bytes.pop_front();
                        check("byte_seq", 32'(tx_data), 32'(eb));
                    end
                end
                if (tx_done) txdone_cnt++;
                if (done) begin
                    done_pulses++;
                    if (exp_runs.size() == 0) begin
                        check("done_unexpected", 32'(done), 32'(0));
                    end else begin
                        er = exp_runs.pop_front();
                        check("run_entry_cnt", 32'(entry_cnt), 32'(er));
                        check("run_error", 32'(error), 32'(0));
                        check("run_busy_low", 32'(busy), 32'(0));
                    end
                end
                if (tx_en) begin
                    en_seen++;
                    en_run_len = prev_tx_en ? en_run_len + 1 : 1;
                end
                // Idle time between consecutive transactions of one run
                if (busy) begin
                    if (tx_en) begin
                        if (gap_armed) check("gap_len", 32'(gap_cnt), 32'(GAP + 2));
                        gap_armed = 0;
                    end else if (prev_tx_en) begin
                        gap_armed = 1;
                        gap_cnt = 1;
                    end else if (gap_armed) begin
                        gap_cnt++;
                    end
                    if (prev_busy && tbl_addr < prev_addr) addr_regress++;
                end else begin
                    gap_armed = 0;
                end
                prev_tx_en = tx_en;
                prev_busy = busy;
                prev_addr = tbl_addr;
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_tbl_addr"}, 32'(tbl_addr), 32'(0));
        check({tag, "_tx_data"}, 32'(tx_data), 32'(0));
        check({tag, "_tx_data_ready"}, 32'(tx_data_ready), 32'(0));
        check({tag, "_tx_en"}, 32'(tx_en), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_error"}, 32'(error), 32'(0));
        check({tag, "_entry_cnt"}, 32'(entry_cnt), 32'(0));
    endtask

    // len valid entries, marker in every later slot (len == NENT: no marker)
    task automatic build_table(input int len);
        for (int i = 0; i < NENT; i++) begin
            if (i < len) tbl[i] = {8'($urandom_range(0, 254)), 8'($urandom), 8'($urandom)};
            else         tbl[i] = {8'hFF, 16'h0000};
        end
    endtask

    // Reference: bytes of every entry up to marker or end of table
    task automatic push_expected(input bit tmo_run);
        int n;
        n = 0;
        while (n < NENT && tbl[n][23:16] != 8'hFF) begin
            exp_bytes.push_back(tbl[n][23:16]);
            exp_bytes.push_back(tbl[n][15:8]);
            exp_bytes.push_back(tbl[n][7:0]);
            n++;
            if (tmo_run) break;
        end
        if (!tmo_run) exp_runs.push_back(n);
    endtask

    task automatic run(input bit noise, input bit tmo_run);
        int cyc;
        push_expected(tmo_run);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("busy_after_start", 32'(busy), 32'(1));
        check("err_clr_on_start", 32'(error), 32'(0));
        cyc = 0;
        while (busy && cyc < BUDGET) begin
            if (noise && $urandom_range(0, 7) == 0) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            cyc++;
        end
        check("run_within_budget", 32'(cyc < BUDGET), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        check("bytes_drained", 32'(exp_bytes.size()), 32'(0));
        check("runs_drained", 32'(exp_runs.size()), 32'(0));
    endtask

    initial begin : stimulus
        int d0, t0, n, got, cyc, b0;
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; use_rom = 1'b0; hang_done = 1'b0; spurious_en = 1'b0;
        build_table(0);
        repeat (3) @(posedge clk);
        #1 check_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Board table from the ROM: two writes then marker
        use_rom = 1'b1;
        tbl[0] = 24'h900155; tbl[1] = 24'h9002AA; tbl[2] = 24'hFF0000;
        d0 = done_pulses; t0 = txdone_cnt;
        run(0, 0);
        check("rom_done_once", 32'(done_pulses - d0), 32'(1));
        check("rom_tx_done_x2", 32'(txdone_cnt - t0), 32'(2));
        check("rom_entry_cnt", 32'(entry_cnt), 32'(2));
        check("rom_error", 32'(error), 32'(0));
        use_rom = 1'b0;

        // Empty table: done three cycles after start, no transmitter activity
        build_table(0);
        push_expected(0);
        en_seen = 0;
        @(posedge clk); #1 start = 1'b1;
        n = 0; got = -1;
        repeat (6) begin
            @(posedge clk); #1 start = 1'b0;
            n++;
            if (done && got < 0) got = n;
        end
        check("empty_done_latency", 32'(got), 32'(3));
        check("empty_tx_en_never", 32'(en_seen), 32'(0));
        check("empty_entry_cnt", 32'(entry_cnt), 32'(0));

        // Watchdog: transmitter never reports STOP
        build_table(int'($urandom_range(1, NENT - 1)));
        hang_done = 1'b1;
        d0 = done_pulses;
        run(0, 1);
        check("tmo_error", 32'(error), 32'(1));
        check("tmo_tx_en", 32'(tx_en), 32'(0));
        check("tmo_busy", 32'(busy), 32'(0));
        check("tmo_no_done", 32'(done_pulses - d0), 32'(0));
        check("tmo_cycles", 32'(en_run_len), 32'(TMO));
        hang_done = 1'b0;
        build_table(int'($urandom_range(1, NENT - 1)));
        run(0, 0);

        // Full table without marker
        build_table(NENT);
        addr_regress = 0;
        run(0, 0);
        check("full_entry_cnt", 32'(entry_cnt), 32'(NENT));
        check("full_addr_no_restart", 32'(addr_regress), 32'(0));

        // Asynchronous reset after the first byte of a transaction
        build_table(int'($urandom_range(2, NENT - 1)));
        push_expected(0);
        b0 = bytes_seen;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (bytes_seen == b0 && cyc < BUDGET) begin
            @(posedge clk);
            cyc++;
        end
        check("rst_wait_first_byte", 32'(cyc < BUDGET), 32'(1));
        #3 rst = 1'b1;
        #1 check_reset("midsend_rst");
        exp_bytes.delete();
        exp_runs.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run(0, 0);

        // Spurious requests outside SEND and start pulses while busy
        spurious_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            build_table(int'($urandom_range(1, NENT - 2)));
            run(1, 0);
        end
        spurious_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
